// File: rtl/cache_axi_rd_arbiter_pkg.sv
// Shared encodings for the cache AXI read arbiter:
// FSM states, requester selects, AXI burst/size codes.
package cache_axi_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RET  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SEL_ICACHE = 1'b0,
    SEL_DCACHE = 1'b1
  } req_sel_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

  // Line requests align to 16 bytes,
  // single-word requests to 4 bytes.
  function automatic logic [31:0] align_addr(
    input logic [31:0] a,
    input logic        line
  );
    return line ? {a[31:4], 4'h0}
                : {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cache_axi_rd_beat_collector.sv
// rd_beat_collector: packs R beats into a line buffer.
// Ports: clk, rst_n, i_clear (zero buffer+count),
//   i_beat/i_data (accepted beat), o_line (packed words).
module rd_beat_collector
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_clear,
  input  logic                             i_beat,
  input  logic [DATA_WIDTH-1:0]            i_data,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] o_line
);

  localparam int CNT_W = $clog2(LINE_WORDS + 1);

  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_buf [LINE_WORDS];
  logic                  w_room;

  // Count saturates at LINE_WORDS so extra
  // beats are dropped instead of wrapping.
  assign w_room = r_cnt < CNT_W'(LINE_WORDS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat && w_room) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++)
        r_buf[i] <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < LINE_WORDS; i++)
        r_buf[i] <= '0;
    end else if (i_beat && w_room) begin
      for (int i = 0; i < LINE_WORDS; i++)
        if (r_cnt == CNT_W'(i))
          r_buf[i] <= i_data;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_line
    assign o_line[g*DATA_WIDTH +: DATA_WIDTH] = r_buf[g];
  end

endmodule

// File: rtl/cache_axi_rd_arbiter.sv
// cache_axi_rd_arbiter: round-robin share of one AXI read
// channel between ICache and DCache refills, one txn in flight.
// Ports: clk/resetn; icache_rd_* / dcache_rd_* request side;
//   *_ret_valid/*_ret_data line return; ar*/r* AXI master.
module cache_axi_rd_arbiter
  import cache_axi_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int ID_WIDTH   = 4,
  parameter int ICACHE_ID  = 0,
  parameter int DCACHE_ID  = 1
) (
  input  logic                             clk,
  input  logic                             resetn,

  input  logic                             icache_rd_req,
  input  logic [31:0]                      icache_rd_addr,
  output logic                             icache_rd_rdy,
  output logic                             icache_ret_valid,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] icache_ret_data,

  input  logic                             dcache_rd_req,
  input  logic                             dcache_rd_type,
  input  logic [31:0]                      dcache_rd_addr,
  output logic                             dcache_rd_rdy,
  output logic                             dcache_ret_valid,
  output logic [DATA_WIDTH*LINE_WORDS-1:0] dcache_ret_data,

  output logic [ID_WIDTH-1:0]              arid,
  output logic [31:0]                      araddr,
  output logic [7:0]                       arlen,
  output logic [2:0]                       arsize,
  output logic [1:0]                       arburst,
  output logic                             arvalid,
  input  logic                             arready,

  input  logic [ID_WIDTH-1:0]              rid,
  input  logic [DATA_WIDTH-1:0]            rdata,
  input  logic [1:0]                       rresp,
  input  logic                             rlast,
  input  logic                             rvalid,
  output logic                             rready
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);
  localparam logic [ID_WIDTH-1:0] I_ID = ID_WIDTH'(ICACHE_ID);
  localparam logic [ID_WIDTH-1:0] D_ID = ID_WIDTH'(DCACHE_ID);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  req_sel_t            r_sel;
  req_sel_t            r_rr;
  req_sel_t            w_win;
  logic [31:0]         r_araddr;
  logic [7:0]          r_arlen;
  logic [ID_WIDTH-1:0] r_arid;

  logic                w_any_req;
  logic                w_ar_hs;
  logic                w_beat;
  logic                w_ret;
  logic [31:0]         w_win_addr;
  logic [7:0]          w_win_len;
  logic [ID_WIDTH-1:0] w_win_id;
  logic [DATA_WIDTH*LINE_WORDS-1:0] w_line;
  logic                w_unused_r;

  // rid/rresp are not checked: one txn is in flight,
  // and error beats still return their data.
  assign w_unused_r = ^{rid, rresp};

  assign w_any_req = icache_rd_req | dcache_rd_req;

  always_comb begin
    w_win = SEL_ICACHE;
    unique case (1'b1)
      (icache_rd_req & dcache_rd_req):  w_win = r_rr;
      (dcache_rd_req & ~icache_rd_req): w_win = SEL_DCACHE;
      (icache_rd_req & ~dcache_rd_req): w_win = SEL_ICACHE;
      default:                          w_win = SEL_ICACHE;
    endcase
  end

  always_comb begin
    w_win_addr = align_addr(icache_rd_addr, 1'b1);
    w_win_len  = LINE_LEN;
    w_win_id   = I_ID;
    if (w_win == SEL_DCACHE) begin
      w_win_addr = align_addr(dcache_rd_addr,
                              dcache_rd_type);
      w_win_len  = dcache_rd_type ? LINE_LEN : 8'd0;
      w_win_id   = D_ID;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_any_req)       w_state_nxt = ST_AR;
      ST_AR:   if (arready)         w_state_nxt = ST_R;
      ST_R:    if (rvalid && rlast) w_state_nxt = ST_RET;
      ST_RET:                       w_state_nxt = ST_IDLE;
      default:                      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // AR fields are captured once at grant so they
  // stay stable while arvalid waits for arready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sel    <= SEL_ICACHE;
      r_araddr <= '0;
      r_arlen  <= '0;
      r_arid   <= '0;
    end else if (r_state == ST_IDLE && w_any_req) begin
      r_sel    <= w_win;
      r_araddr <= w_win_addr;
      r_arlen  <= w_win_len;
      r_arid   <= w_win_id;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rr <= SEL_DCACHE;
    end else if (r_state == ST_RET) begin
      r_rr <= (r_sel == SEL_DCACHE) ? SEL_ICACHE
                                    : SEL_DCACHE;
    end
  end

  assign arvalid = (r_state == ST_AR);
  assign araddr  = r_araddr;
  assign arlen   = r_arlen;
  assign arid    = r_arid;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  assign w_ar_hs       = arvalid & arready;
  assign icache_rd_rdy = w_ar_hs & (r_sel == SEL_ICACHE);
  assign dcache_rd_rdy = w_ar_hs & (r_sel == SEL_DCACHE);

  assign rready = (r_state == ST_R);
  assign w_beat = rvalid & rready;
  assign w_ret  = (r_state == ST_RET);

  rd_beat_collector #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_collect (
    .clk     (clk),
    .rst_n   (resetn),
    .i_clear (w_ret),
    .i_beat  (w_beat),
    .i_data  (rdata),
    .o_line  (w_line)
  );

  assign icache_ret_valid = w_ret & (r_sel == SEL_ICACHE);
  assign dcache_ret_valid = w_ret & (r_sel == SEL_DCACHE);

  // Buffer is only exposed to the port being answered.
  assign icache_ret_data = icache_ret_valid ? w_line : '0;
  assign dcache_ret_data = dcache_ret_valid ? w_line : '0;

endmodule

// File: tb/tb_cache_axi_rd_arbiter.sv
// Scoreboard bench for cache_axi_rd_arbiter: request-level
// arbitration model, randomized AXI slave, negedge monitor.
module tb_cache_axi_rd_arbiter;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         icache_rd_req = 1'b0;
  logic [31:0]  icache_rd_addr = '0;
  logic         icache_rd_rdy, icache_ret_valid;
  logic [127:0] icache_ret_data;
  logic         dcache_rd_req = 1'b0;
  logic         dcache_rd_type = 1'b0;
  logic [31:0]  dcache_rd_addr = '0;
  logic         dcache_rd_rdy, dcache_ret_valid;
  logic [127:0] dcache_ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [3:0]   rid = '0;
  logic [31:0]  rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;

  cache_axi_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .icache_rd_req(icache_rd_req),
    .icache_rd_addr(icache_rd_addr),
    .icache_rd_rdy(icache_rd_rdy),
    .icache_ret_valid(icache_ret_valid),
    .icache_ret_data(icache_ret_data),
    .dcache_rd_req(dcache_rd_req),
    .dcache_rd_type(dcache_rd_type),
    .dcache_rd_addr(dcache_rd_addr),
    .dcache_rd_rdy(dcache_rd_rdy),
    .dcache_ret_valid(dcache_ret_valid),
    .dcache_ret_data(dcache_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              stall;
    int              gapmax;
    int              nbeats;
    logic [7:0][31:0] w;
  } plan_t;
  typedef struct {
    bit          d;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
  } exp_ar_t;
  typedef struct {
    bit           d;
    logic [127:0] data;
  } exp_ret_t;

  plan_t    plan_q[$];
  exp_ar_t  exp_ar_q[$];
  exp_ret_t exp_ret_q[$];

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_cyc = -10;
  int beats_seen = 0;
  bit ar_fire = 0;
  bit r_fire = 0;
  bit m_rr = 1;  // 1: DCache wins a tie

  int          ni, nd;
  logic [31:0] ra_i[2], ra_d[2];
  logic        rt_d[2];
  plan_t       rp_i[2], rp_d[2];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, expected none (cycle %0d)",
             nm, cyc);
  endtask

  function automatic logic [127:0] exp_line(input plan_t p);
    logic [127:0] l;
    l = '0;
    for (int k = 0; k < 4; k++)
      if (k < p.nbeats) l[k*32 +: 32] = p.w[k];
    return l;
  endfunction

  // Request-level model: at every arbitration point every
  // cache with work left is pending; tie goes to m_rr.
  task automatic model_round();
    int ki, kd;
    bit w;
    exp_ar_t ea;
    exp_ret_t er;
    ki = 0;
    kd = 0;
    while (ki < ni || kd < nd) begin
      if (ki < ni && kd < nd) w = m_rr;
      else w = (kd < nd);
      ea.d = w;
      er.d = w;
      if (w) begin
        ea.addr = rt_d[kd] ? (ra_d[kd] & 32'hFFFF_FFF0)
                           : (ra_d[kd] & 32'hFFFF_FFFC);
        ea.len  = rt_d[kd] ? 8'd3 : 8'd0;
        ea.id   = 4'd1;
        er.data = exp_line(rp_d[kd]);
        plan_q.push_back(rp_d[kd]);
        kd++;
      end else begin
        ea.addr = ra_i[ki] & 32'hFFFF_FFF0;
        ea.len  = 8'd3;
        ea.id   = 4'd0;
        er.data = exp_line(rp_i[ki]);
        plan_q.push_back(rp_i[ki]);
        ki++;
      end
      exp_ar_q.push_back(ea);
      exp_ret_q.push_back(er);
      m_rr = !w;
    end
  endtask

  always @(negedge clk) begin
    exp_ar_t ea;
    exp_ret_t er;
    logic exp_ir, exp_dr;
    cyc++;
    ar_fire = arvalid && arready;
    r_fire  = rvalid && rready;
    exp_ir = 1'b0;
    exp_dr = 1'b0;
    if (resetn) begin
      if (r_fire) begin
        beats_seen++;
        if (rlast) last_cyc = cyc;
      end
      if (arvalid) begin
        if (exp_ar_q.size() == 0) fail_now("unexpected_ar");
        else begin
          ea = exp_ar_q[0];
          chk("araddr", 128'(araddr), 128'(ea.addr));
          chk("arlen", 128'(arlen), 128'(ea.len));
          chk("arid", 128'(arid), 128'(ea.id));
          chk("arsize", 128'(arsize), 128'(3'b010));
          chk("arburst", 128'(arburst), 128'(2'b01));
          if (ar_fire) begin
            exp_ir = !ea.d;
            exp_dr = ea.d;
            void'(exp_ar_q.pop_front());
          end
        end
      end
      chk("icache_rd_rdy", 128'(icache_rd_rdy), 128'(exp_ir));
      chk("dcache_rd_rdy", 128'(dcache_rd_rdy), 128'(exp_dr));
      if (icache_ret_valid || dcache_ret_valid) begin
        if (exp_ret_q.size() == 0) fail_now("unexpected_ret");
        else begin
          er = exp_ret_q.pop_front();
          chk("icache_ret_valid", 128'(icache_ret_valid),
              128'(!er.d));
          chk("dcache_ret_valid", 128'(dcache_ret_valid),
              128'(er.d));
          chk(er.d ? "dcache_ret_data" : "icache_ret_data",
              er.d ? dcache_ret_data : icache_ret_data,
              er.data);
          chk("ret_latency", 128'(cyc - last_cyc), 128'(1));
        end
      end
      if (!icache_ret_valid)
        chk("icache_ret_data_idle", icache_ret_data, '0);
      if (!dcache_ret_valid)
        chk("dcache_ret_data_idle", dcache_ret_data, '0);
    end
  end

  // AXI slave: follows the plan queued for each grant.
  initial begin : slave
    int ph, stall, gap, beat;
    bit loaded;
    plan_t p;
    ph = 0; stall = 0; gap = 0; beat = 0; loaded = 0;
    p.stall = 0; p.gapmax = 0; p.nbeats = 1; p.w = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        ph = 0;
        loaded = 0;
        arready = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        continue;
      end
      if (ph == 0) begin
        if (ar_fire) begin
          arready = 1'b0;
          ph = 1;
          beat = 0;
          loaded = 0;
          gap = $urandom_range(0, p.gapmax);
        end else if (arvalid) begin
          if (!loaded) begin
            if (plan_q.size() > 0) p = plan_q.pop_front();
            else p.nbeats = 1;
            stall = p.stall;
            loaded = 1;
          end
          if (stall > 0) begin
            stall--;
            arready = 1'b0;
          end else arready = 1'b1;
        end else arready = 1'b0;
      end
      if (ph == 1) begin
        if (r_fire) begin
          beat++;
          gap = $urandom_range(0, p.gapmax);
        end
        if (beat >= p.nbeats) begin
          rvalid = 1'b0;
          rlast = 1'b0;
          ph = 0;
        end else if (gap > 0) begin
          gap--;
          rvalid = 1'b0;
          rlast = 1'b0;
        end else begin
          rvalid = 1'b1;
          rdata = p.w[beat];
          rlast = (beat == p.nbeats - 1);
          rid = 4'($urandom);
          rresp = 2'($urandom);
        end
      end
    end
  end

  task automatic drive(input bit d, input int n);
    int t;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (d) begin
        dcache_rd_req = 1'b1;
        dcache_rd_addr = ra_d[k];
        dcache_rd_type = rt_d[k];
      end else begin
        icache_rd_req = 1'b1;
        icache_rd_addr = ra_i[k];
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(d ? dcache_rd_rdy : icache_rd_rdy)
                 && t < 3000);
      if (t >= 3000)
        fail_now(d ? "dcache_rdy_timeout" : "icache_rdy_timeout");
    end
    if (n > 0) begin
      @(posedge clk);
      #1;
      if (d) dcache_rd_req = 1'b0;
      else icache_rd_req = 1'b0;
    end
  endtask

  task automatic run_round();
    int t;
    model_round();
    fork
      drive(1'b0, ni);
      drive(1'b1, nd);
    join
    t = 0;
    while (exp_ret_q.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_ret_q.size() > 0) begin
      fail_now("round_timeout");
      exp_ret_q.delete();
      exp_ar_q.delete();
      plan_q.delete();
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic mk_plan(output plan_t p, input int st,
                         input int gm, input int nb);
    p.stall = st;
    p.gapmax = gm;
    p.nbeats = nb;
    for (int k = 0; k < 8; k++) p.w[k] = $urandom;
  endtask

  task automatic gen(input bit d, output logic [31:0] a,
                     output logic t, output plan_t p);
    int r, nb;
    a = $urandom;
    t = d ? 1'($urandom_range(0, 1)) : 1'b1;
    r = $urandom_range(0, 5);
    if (!t) nb = 1;
    else if (r == 0) nb = $urandom_range(1, 3);
    else if (r == 1) nb = $urandom_range(5, 7);
    else nb = 4;
    mk_plan(p, $urandom_range(0, 3), $urandom_range(0, 2), nb);
  endtask

  task automatic gen_round(input int a, input int b);
    logic tt;
    ni = a;
    nd = b;
    for (int k = 0; k < 2; k++) begin
      gen(1'b0, ra_i[k], tt, rp_i[k]);
      gen(1'b1, ra_d[k], rt_d[k], rp_d[k]);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, 128'(arvalid), '0);
    chk({tag, "_rready"}, 128'(rready), '0);
    chk({tag, "_i_rdy"}, 128'(icache_rd_rdy), '0);
    chk({tag, "_d_rdy"}, 128'(dcache_rd_rdy), '0);
    chk({tag, "_i_ret_valid"}, 128'(icache_ret_valid), '0);
    chk({tag, "_d_ret_valid"}, 128'(dcache_ret_valid), '0);
    chk({tag, "_i_ret_data"}, icache_ret_data, '0);
    chk({tag, "_d_ret_data"}, dcache_ret_data, '0);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("[TB] %0d tests run, %0d failed",
             n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, t;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    @(posedge clk);
    #3;
    resetn = 1'b1;

    gen_round(1, 0);
    ra_i[0] = 32'h1FC0_0014;
    mk_plan(rp_i[0], 0, 0, 4);
    for (int k = 0; k < 4; k++)
      rp_i[0].w[k] = 32'hA000_0000 + 32'(k);
    run_round();

    gen_round(1, 1);
    run_round();
    gen_round(1, 1);
    run_round();
    gen_round(1, 2);
    run_round();

    gen_round(0, 1);
    ra_d[0] = 32'hBFAF_8002;
    rt_d[0] = 1'b0;
    mk_plan(rp_d[0], 0, 0, 1);
    rp_d[0].w[0] = 32'hDEAD_BEEF;
    run_round();

    gen_round(1, 0);
    mk_plan(rp_i[0], 5, 3, 4);
    run_round();

    gen_round(1, 0);
    mk_plan(rp_i[0], 0, 1, 2);
    run_round();
    gen_round(0, 1);
    rt_d[0] = 1'b1;
    mk_plan(rp_d[0], 1, 1, 6);
    run_round();

    for (int r = 0; r < 40; r++) begin
      gen_round($urandom_range(0, 2), $urandom_range(0, 2));
      if (ni == 0 && nd == 0) ni = 1;
      run_round();
    end

    gen_round(0, 1);
    rt_d[0] = 1'b1;
    mk_plan(rp_d[0], 0, 1, 4);
    model_round();
    b0 = beats_seen;
    drive(1'b1, 1);
    t = 0;
    while (beats_seen < b0 + 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_now("beat_wait_timeout");
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_idle_outputs("midreset");
    exp_ar_q.delete();
    exp_ret_q.delete();
    plan_q.delete();
    m_rr = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    resetn = 1'b1;

    gen_round(1, 1);
    run_round();
    gen_round(0, 1);
    rt_d[0] = 1'b1;
    mk_plan(rp_d[0], 0, 0, 1);
    run_round();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
